// File: rtl/heater_pkg.sv
// Shared definitions for the bath-heater command controller.
// Contents:
//   state_t          controller state (OFF/IDLE/SET/RUN/PURGE)
//   KEY_*            key indices on the 16-bit key pulse bus (0-9 are digits)
//   HEAT_*           heat level codes driven on heat_lvl
//   next_heat()      heat level cycle 0 -> 1 -> 2 -> 0
//   bcd_dec()        two-digit BCD decrement (caller never passes 00)
package heater_pkg;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_IDLE  = 3'd1,
        ST_SET   = 3'd2,
        ST_RUN   = 3'd3,
        ST_PURGE = 3'd4
    } state_t;

    localparam logic [3:0] KEY_PWR   = 4'd10;
    localparam logic [3:0] KEY_HEAT  = 4'd11;
    localparam logic [3:0] KEY_FAN   = 4'd12;
    localparam logic [3:0] KEY_LIGHT = 4'd13;
    localparam logic [3:0] KEY_TIMER = 4'd14;
    localparam logic [3:0] KEY_OK    = 4'd15;

    localparam logic [1:0] HEAT_OFF  = 2'd0;
    localparam logic [1:0] HEAT_LOW  = 2'd1;
    localparam logic [1:0] HEAT_HIGH = 2'd2;

    function automatic logic [1:0] next_heat(input logic [1:0] h);
        logic [1:0] r;
        case (h)
            HEAT_OFF: r = HEAT_LOW;
            HEAT_LOW: r = HEAT_HIGH;
            default:  r = HEAT_OFF;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd0) begin
            r = {v[7:4] - 4'd1, 4'd9};
        end else begin
            r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/heater_key_ctrl_sec_ticker.sv
// One-second prescaler for the heater controller.
// Ports:
//   sys_clk  in  system clock
//   rst_n    in  asynchronous active-low reset
//   clr_i    in  synchronous clear (restarts the second from zero)
//   tick_o   out single-cycle strobe, once every CLK_HZ cycles
module sec_ticker #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic tick_o
);

    localparam int            CW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/heater_key_ctrl.sv
// Bath-heater command controller. Takes one-cycle key pulses from the keypad
// scanner and owns power, heat level, fan, light and the BCD auto-off timer.
// Ports:
//   sys_clk       in   system clock
//   rst_n         in   asynchronous active-low reset
//   key_pulse     in   [15:0] one-cycle key pulses (0-9 digits, 10-15 A-F)
//   power_on      out  heater enabled
//   heat_lvl      out  [1:0] 0 off, 1 low, 2 high
//   fan_on        out  fan drive
//   light_on      out  light drive
//   timer_active  out  countdown running
//   disp_bcd      out  [7:0] entry buffer in SET, remaining minutes in RUN, else 00
//   set_mode      out  high while in SET
//   dbg_state     out  [2:0] current controller state (state_t encoding)
// All functional outputs are registered from the state registers, so a key
// accepted at edge n is visible on the outputs after edge n+1.
module heater_key_ctrl
    import heater_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int ENTRY_TO_S = 10,
    parameter int PURGE_S    = 30
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic [15:0] key_pulse,
    output logic        power_on,
    output logic [1:0]  heat_lvl,
    output logic        fan_on,
    output logic        light_on,
    output logic        timer_active,
    output logic [7:0]  disp_bcd,
    output logic        set_mode,
    output logic [2:0]  dbg_state
);

    localparam int              TO_W    = $clog2(ENTRY_TO_S + 1);
    localparam int              PG_W    = $clog2(PURGE_S + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ENTRY_TO_S - 1);
    localparam logic [PG_W-1:0] PG_LAST = PG_W'(PURGE_S - 1);

    state_t          state_q, state_d;
    state_t          ret_q, ret_d;        // state to resume when SET exits
    logic [1:0]      heat_q, heat_d;
    logic            fan_user_q, fan_user_d;
    logic            light_q, light_d;
    logic [7:0]      entry_q, entry_d;    // BCD entry buffer
    logic [7:0]      remain_q, remain_d;  // BCD remaining minutes
    logic [5:0]      sec_q, sec_d;        // seconds within the current minute
    logic [TO_W-1:0] to_q, to_d;          // idle seconds in SET
    logic [PG_W-1:0] purge_q, purge_d;    // seconds spent in PURGE

    logic            power_on_q, fan_on_q, light_on_q, timer_active_q, set_mode_q;
    logic [1:0]      heat_lvl_q;
    logic [7:0]      disp_bcd_q;

    logic            key_vld;
    logic [3:0]      key_idx;
    logic            tick;
    logic            go_off;
    logic            timer_stop;          // key this cycle cancels the pending decrement
    logic            pre_clr;
    logic            counting;

    sec_ticker #(.CLK_HZ(CLK_HZ)) u_sec_ticker (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .clr_i   (pre_clr),
        .tick_o  (tick)
    );

    always_comb begin
        // Lowest set bit wins; scanning downward leaves the lowest index last.
        key_vld = |key_pulse;
        key_idx = 4'd0;
        for (int k = 15; k >= 0; k--) begin
            if (key_pulse[k]) key_idx = 4'(k);
        end

        state_d    = state_q;
        ret_d      = ret_q;
        heat_d     = heat_q;
        fan_user_d = fan_user_q;
        light_d    = light_q;
        entry_d    = entry_q;
        remain_d   = remain_q;
        sec_d      = sec_q;
        to_d       = to_q;
        purge_d    = purge_q;
        go_off     = 1'b0;
        timer_stop = 1'b0;
        pre_clr    = 1'b0;

        // Key handling comes first; the timed events below see its result.
        if (key_vld) begin
            if (key_idx == KEY_LIGHT) light_d = !light_q;
            if (state_q == ST_SET) to_d = '0;
            case (state_q)
                ST_OFF: begin
                    if (key_idx == KEY_PWR) begin
                        state_d    = ST_IDLE;
                        heat_d     = HEAT_OFF;
                        fan_user_d = 1'b0;
                    end
                end
                ST_PURGE: begin
                    if (key_idx == KEY_PWR) go_off = 1'b1;
                end
                default: begin
                    case (key_idx)
                        KEY_PWR:  go_off = 1'b1;
                        KEY_HEAT: heat_d = next_heat(heat_q);
                        KEY_FAN:  fan_user_d = !fan_user_q;
                        KEY_TIMER: begin
                            if (state_q == ST_SET) begin
                                state_d = ret_q;
                            end else begin
                                ret_d   = state_q;
                                state_d = ST_SET;
                                entry_d = 8'h00;
                                to_d    = '0;
                            end
                        end
                        KEY_OK: begin
                            if (state_q == ST_SET) begin
                                timer_stop = 1'b1;
                                sec_d      = '0;
                                if (entry_q == 8'h00) begin
                                    state_d  = ST_IDLE;
                                    remain_d = 8'h00;
                                end else begin
                                    state_d  = ST_RUN;
                                    remain_d = entry_q;
                                    pre_clr  = 1'b1;
                                end
                            end
                        end
                        default: begin
                            if ((state_q == ST_SET) && (key_idx <= 4'd9)) begin
                                entry_d = {entry_q[3:0], key_idx};
                            end
                        end
                    endcase
                end
            endcase
        end

        if (go_off) begin
            timer_stop = 1'b1;
            state_d    = ST_OFF;
            heat_d     = HEAT_OFF;
            fan_user_d = 1'b0;
            entry_d    = 8'h00;
            remain_d   = 8'h00;
            sec_d      = '0;
            purge_d    = '0;
        end

        // Countdown keeps running while the user edits a new value from RUN.
        counting = (state_q == ST_RUN) || ((state_q == ST_SET) && (ret_q == ST_RUN));
        if (counting && tick && !timer_stop) begin
            if (sec_q == 6'd59) begin
                sec_d = '0;
                if (remain_q == 8'h01) begin
                    state_d    = ST_PURGE;
                    heat_d     = HEAT_OFF;
                    fan_user_d = 1'b0;
                    remain_d   = 8'h00;
                    entry_d    = 8'h00;
                    purge_d    = '0;
                end else begin
                    remain_d = bcd_dec(remain_q);
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end

        if ((state_q == ST_SET) && (state_d == ST_SET) && !key_vld && tick) begin
            if (to_q == TO_LAST) begin
                state_d = ret_q;
                to_d    = '0;
            end else begin
                to_d = to_q + 1'b1;
            end
        end

        if ((state_q == ST_PURGE) && (state_d == ST_PURGE) && tick) begin
            if (purge_q == PG_LAST) begin
                state_d = ST_OFF;
                purge_d = '0;
            end else begin
                purge_d = purge_q + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_OFF;
            ret_q          <= ST_OFF;
            heat_q         <= HEAT_OFF;
            fan_user_q     <= 1'b0;
            light_q        <= 1'b0;
            entry_q        <= 8'h00;
            remain_q       <= 8'h00;
            sec_q          <= '0;
            to_q           <= '0;
            purge_q        <= '0;
            power_on_q     <= 1'b0;
            heat_lvl_q     <= HEAT_OFF;
            fan_on_q       <= 1'b0;
            light_on_q     <= 1'b0;
            timer_active_q <= 1'b0;
            disp_bcd_q     <= 8'h00;
            set_mode_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            ret_q          <= ret_d;
            heat_q         <= heat_d;
            fan_user_q     <= fan_user_d;
            light_q        <= light_d;
            entry_q        <= entry_d;
            remain_q       <= remain_d;
            sec_q          <= sec_d;
            to_q           <= to_d;
            purge_q        <= purge_d;
            power_on_q     <= (state_q != ST_OFF);
            heat_lvl_q     <= heat_q;
            // Heat is never driven without airflow; purge forces the fan.
            fan_on_q       <= ((state_q != ST_OFF) && (fan_user_q || (heat_q != HEAT_OFF)))
                              || (state_q == ST_PURGE);
            light_on_q     <= light_q;
            timer_active_q <= (state_q == ST_RUN) || ((state_q == ST_SET) && (ret_q == ST_RUN));
            disp_bcd_q     <= (state_q == ST_SET) ? entry_q :
                              (state_q == ST_RUN) ? remain_q : 8'h00;
            set_mode_q     <= (state_q == ST_SET);
        end
    end

    assign power_on     = power_on_q;
    assign heat_lvl     = heat_lvl_q;
    assign fan_on       = fan_on_q;
    assign light_on     = light_on_q;
    assign timer_active = timer_active_q;
    assign disp_bcd     = disp_bcd_q;
    assign set_mode     = set_mode_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_heater_key_ctrl.sv
module tb_heater_key_ctrl;

  localparam int CLK_HZ     = 10;
  localparam int ENTRY_TO_S = 3;
  localparam int PURGE_S    = 2;

  // ---------------- clock / reset ----------------
  logic        sys_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic [15:0] key_pulse = '0;
  logic        power_on, fan_on, light_on, timer_active, set_mode;
  logic [1:0]  heat_lvl;
  logic [7:0]  disp_bcd;
  logic [2:0]  dbg_state;

  always #5 sys_clk = ~sys_clk;

  heater_key_ctrl #(
    .CLK_HZ     (CLK_HZ),
    .ENTRY_TO_S (ENTRY_TO_S),
    .PURGE_S    (PURGE_S)
  ) dut (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .key_pulse    (key_pulse),
    .power_on     (power_on),
    .heat_lvl     (heat_lvl),
    .fan_on       (fan_on),
    .light_on     (light_on),
    .timer_active (timer_active),
    .disp_bcd     (disp_bcd),
    .set_mode     (set_mode),
    .dbg_state    (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  // Modes: 0 off, 1 idle, 2 set, 3 run, 4 purge. Minutes and entry kept as
  // plain decimal integers; BCD only appears when forming the display.
  int m_mode, m_heat, m_ent, m_min, m_sec, m_to, m_pg, m_pre;
  bit m_from_run, m_fan, m_light;

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [14:0] model_out();
    logic p, f, t, s;
    logic [7:0] d;
    p = (m_mode != 0);
    f = (p && (m_fan || m_heat != 0)) || (m_mode == 4);
    t = (m_mode == 3) || (m_mode == 2 && m_from_run);
    s = (m_mode == 2);
    d = (m_mode == 2) ? to_bcd(m_ent) : (m_mode == 3) ? to_bcd(m_min) : 8'h00;
    return {p, 2'(m_heat), f, m_light, t, d, s};
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_heat = 0; m_ent = 0; m_min = 0; m_sec = 0;
    m_to = 0; m_pg = 0; m_pre = 0; m_from_run = 0; m_fan = 0; m_light = 0;
  endfunction

  function automatic void model_off();
    m_mode = 0; m_heat = 0; m_fan = 0; m_min = 0; m_sec = 0;
    m_ent = 0; m_from_run = 0; m_pg = 0;
  endfunction

  function automatic void model_step(input logic [15:0] keys);
    bit tick, stop, keyed, counting;
    int k, mode0;
    mode0 = m_mode;
    tick  = (m_pre == CLK_HZ - 1);
    m_pre = tick ? 0 : m_pre + 1;
    k = -1;
    for (int i = 15; i >= 0; i--) if (keys[i]) k = i;
    keyed = (k >= 0);
    stop  = 0;
    if (k == 13) m_light = !m_light;
    if (keyed && mode0 == 2) m_to = 0;
    if (k == 10) begin
      if (m_mode == 0) begin m_mode = 1; m_heat = 0; m_fan = 0; end
      else begin model_off(); stop = 1; end
    end else if (keyed && m_mode >= 1 && m_mode <= 3) begin
      if (k == 11) m_heat = (m_heat + 1) % 3;
      else if (k == 12) m_fan = !m_fan;
      else if (k == 14) begin
        if (m_mode == 2) m_mode = m_from_run ? 3 : 1;
        else begin m_from_run = (m_mode == 3); m_mode = 2; m_ent = 0; m_to = 0; end
      end else if (k == 15 && m_mode == 2) begin
        stop = 1; m_sec = 0;
        if (m_ent == 0) begin m_mode = 1; m_from_run = 0; m_min = 0; end
        else begin m_mode = 3; m_min = m_ent; m_pre = 0; end
      end else if (k <= 9 && m_mode == 2) m_ent = (m_ent % 10) * 10 + k;
    end
    counting = (mode0 == 3) || (mode0 == 2 && m_from_run);
    if (counting && tick && !stop) begin
      if (m_sec == 59) begin
        m_sec = 0;
        m_min = m_min - 1;
        if (m_min == 0) begin
          m_mode = 4; m_heat = 0; m_fan = 0; m_pg = 0; m_from_run = 0; m_ent = 0;
        end
      end else m_sec = m_sec + 1;
    end
    if (mode0 == 2 && m_mode == 2 && !keyed && tick) begin
      m_to = m_to + 1;
      if (m_to == ENTRY_TO_S) begin m_mode = m_from_run ? 3 : 1; m_to = 0; end
    end
    if (mode0 == 4 && m_mode == 4 && tick) begin
      m_pg = m_pg + 1;
      if (m_pg == PURGE_S) model_off();
    end
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] dut_out();
    return {power_on, heat_lvl, fan_on, light_on, timer_active, disp_bcd, set_mode};
  endfunction

  // ---------------- driver tasks ----------------
  // Every task starts and ends right after a falling edge.
  task automatic cycle(input logic [15:0] keys);
    logic [14:0] exp;
    key_pulse = keys;
    exp = model_out();
    model_step(keys);
    @(posedge sys_clk);
    #1;
    key_pulse = '0;
    check("cycle", 16'(dut_out()), 16'(exp));
    @(negedge sys_clk);
  endtask

  task automatic press(input int k);
    logic [15:0] kv;
    kv = '0;
    kv[k] = 1'b1;
    cycle(kv);
    cycle('0);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle('0);
  endtask

  task automatic do_reset();
    key_pulse = '0;
    rst_n = 1'b0;
    #1;
    check("reset_outs", 16'(dut_out()), 16'h0000);
    model_reset();
    @(negedge sys_clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    @(negedge sys_clk);
    @(negedge sys_clk);
    #1;
    check("por_outs", 16'(dut_out()), 16'h0000);
    @(negedge sys_clk);
    rst_n = 1'b1;

    // power, heat cycling and fan interlock
    press(10); press(11); press(11);
    check("heat2_power", 16'(power_on), 16'd1);
    check("heat2_lvl", 16'(heat_lvl), 16'd2);
    check("heat2_fan", 16'(fan_on), 16'd1);
    press(11);
    check("heat0_lvl", 16'(heat_lvl), 16'd0);
    check("heat0_fan", 16'(fan_on), 16'd0);

    // A and D together: only A accepted
    press(10);
    check("off_again", 16'(power_on), 16'd0);
    cycle(16'h2400); cycle('0);
    check("arb_power", 16'(power_on), 16'd1);
    check("arb_light", 16'(light_on), 16'd0);

    // timer entry 12, then one minute down
    press(14); press(1); press(2); press(15);
    check("run12_disp", 16'(disp_bcd), 16'h0012);
    check("run12_active", 16'(timer_active), 16'd1);
    idle(600);
    check("run11_disp", 16'(disp_bcd), 16'h0011);

    // 10 -> 09 borrow
    press(10); press(10);
    press(14); press(1); press(0); press(15);
    check("run10_disp", 16'(disp_bcd), 16'h0010);
    idle(600);
    check("run09_disp", 16'(disp_bcd), 16'h0009);

    // expiry into purge, then off
    press(10); press(10); press(11);
    press(14); press(0); press(1); press(15);
    check("run01_heat", 16'(heat_lvl), 16'd1);
    idle(600);
    check("purge_heat", 16'(heat_lvl), 16'd0);
    check("purge_fan", 16'(fan_on), 16'd1);
    check("purge_power", 16'(power_on), 16'd1);
    check("purge_timer", 16'(timer_active), 16'd0);
    idle(25);
    check("after_purge_power", 16'(power_on), 16'd0);
    check("after_purge_fan", 16'(fan_on), 16'd0);

    // SET timeout and power-off from SET
    press(10); press(14);
    check("set_mode_on", 16'(set_mode), 16'd1);
    idle(35);
    check("timeout_set_mode", 16'(set_mode), 16'd0);
    check("timeout_power", 16'(power_on), 16'd1);
    press(14); press(5); press(10);
    check("set_a_power", 16'(power_on), 16'd0);
    check("set_a_disp", 16'(disp_bcd), 16'h0000);

    // reset in the middle of a countdown, then light in OFF
    press(10); press(14); press(0); press(5); press(15);
    idle(100);
    check("run05_disp", 16'(disp_bcd), 16'h0005);
    do_reset();
    press(13);
    check("light_in_off", 16'(light_on), 16'd1);
    check("light_in_off_power", 16'(power_on), 16'd0);

    // randomized phase checked cycle by cycle against the model
    for (int n = 0; n < 4000; n++) begin
      int r;
      logic [15:0] kv;
      r = $urandom_range(0, 99);
      kv = '0;
      if (r == 0) begin
        do_reset();
      end else begin
        if (r >= 60 && r < 90) kv[$urandom_range(0, 15)] = 1'b1;
        else if (r >= 90) kv = 16'($urandom);
        cycle(kv);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
